// File: rtl/ch77_restart_poller.sv
// Monitor-side master for restart-monitor channel 77: periodic alarm polls, optional latch clears,
// and a small timestamped first-word-fall-through FIFO of non-zero alarm snapshots.
module ch77_restart_poller #(
  parameter int unsigned POLL_PERIOD = 1024,
  parameter int unsigned PULSE_CYC   = 2,
  parameter int unsigned STROBE_CYC  = 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned STAMP_W     = 16
) (
  input  logic               SIM_CLK,
  input  logic               SIM_RST,
  input  logic               enable,
  input  logic               auto_clr,
  input  logic               clear_req,
  input  logic               ovf_clr,
  input  logic               MDT01,
  input  logic               MDT02,
  input  logic               MDT03,
  input  logic               MDT04,
  input  logic               MDT05,
  input  logic               MDT06,
  input  logic               MDT07,
  input  logic               MDT08,
  input  logic               MDT09,
  output logic               MWL01,
  output logic               MWL02,
  output logic               MWL03,
  output logic               MWL04,
  output logic               MWL05,
  output logic               MWL06,
  output logic               MT01,
  output logic               MWSG,
  output logic               MT12,
  output logic               MRCH,
  output logic               MWCH,
  output logic               alarm_valid,
  input  logic               alarm_ready,
  output logic [8:0]         alarm_data,
  output logic [STAMP_W-1:0] alarm_stamp,
  output logic               ovf,
  output logic               busy
);

  localparam int unsigned TMR_W  = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int unsigned PH_MAX = (PULSE_CYC > STROBE_CYC) ? PULSE_CYC : STROBE_CYC;
  localparam int unsigned CNT_W  = $clog2(PH_MAX + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W  = PTR_W + 1;
  localparam int unsigned DAT_W  = 9;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_T01, S_GAP, S_STRB, S_T12
  } state_t;

  typedef struct packed {
    logic [DAT_W-1:0]   data;
    logic [STAMP_W-1:0] stamp;
  } entry_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic               start_rd, start_wr;
  logic               mwl_d, mt01_d, mt12_d, mrch_d, mwch_d, busy_d;
  logic               mwl_q;
  logic               poll_pend, clr_pend;
  logic [TMR_W-1:0]   tmr_q;
  logic [STAMP_W-1:0] stamp_q, samp_stamp_q;
  logic [DAT_W-1:0]   mdt, samp_q;
  entry_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wp_q, rp_q;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               rd_last, rd_done, full, pop, push, drop;

  assign mdt = {MDT09, MDT08, MDT07, MDT06, MDT05, MDT04, MDT03, MDT02, MDT01};

  assign {MWL06, MWL05, MWL04, MWL03, MWL02, MWL01} = {6{mwl_q}};

  // Next state plus next values of the registered bus outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    start_rd = 1'b0;
    start_wr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (clr_pend) begin
          state_d  = S_ADDR;
          wr_d     = 1'b1;
          start_wr = 1'b1;
        end else if (poll_pend) begin
          state_d  = S_ADDR;
          wr_d     = 1'b0;
          start_rd = 1'b1;
        end
      end
      S_ADDR: begin
        state_d = S_T01;
        cnt_d   = '0;
      end
      S_T01: begin
        if (cnt_q == CNT_W'(PULSE_CYC - 1)) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        state_d = S_STRB;
        cnt_d   = '0;
      end
      S_STRB: begin
        if (cnt_q == CNT_W'(STROBE_CYC - 1)) begin
          state_d = S_T12;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_T12: begin
        if (cnt_q == CNT_W'(PULSE_CYC - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    mwl_d  = (state_d == S_ADDR) || (state_d == S_T01) || (state_d == S_GAP) || (state_d == S_STRB);
    mt01_d = (state_d == S_T01);
    mt12_d = (state_d == S_IDLE) || (state_d == S_T12);
    mrch_d = (state_d == S_STRB) && !wr_d;
    mwch_d = (state_d == S_STRB) && wr_d;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      mwl_q   <= 1'b0;
      MT01    <= 1'b0;
      MWSG    <= 1'b0;
      MT12    <= 1'b1;
      MRCH    <= 1'b0;
      MWCH    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      mwl_q   <= mwl_d;
      MT01    <= mt01_d;
      MWSG    <= mt01_d;
      MT12    <= mt12_d;
      MRCH    <= mrch_d;
      MWCH    <= mwch_d;
      busy    <= busy_d;
    end
  end

  // Poll timer, pending requests and free-running stamp.
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      tmr_q     <= '0;
      poll_pend <= 1'b0;
      clr_pend  <= 1'b0;
      stamp_q   <= '0;
    end else begin
      stamp_q <= stamp_q + STAMP_W'(1);
      if (!enable) begin
        tmr_q     <= TMR_W'(POLL_PERIOD - 1);
        poll_pend <= 1'b0;
      end else if (tmr_q == '0) begin
        tmr_q     <= TMR_W'(POLL_PERIOD - 1);
        poll_pend <= 1'b1;
      end else begin
        tmr_q <= tmr_q - TMR_W'(1);
        if (start_rd) poll_pend <= 1'b0;
      end
      // A request arriving while one is pending merges into it.
      if (start_wr) clr_pend <= 1'b0;
      else if (clear_req || (push && auto_clr)) clr_pend <= 1'b1;
    end
  end

  assign rd_last = (state_q == S_STRB) && !wr_q && (cnt_q == CNT_W'(STROBE_CYC - 1));
  assign rd_done = (state_q == S_T12) && !wr_q && (cnt_q == '0);
  assign full    = (occ_q == OCC_W'(FIFO_DEPTH));
  assign pop     = alarm_valid && alarm_ready;
  assign push    = rd_done && (samp_q != '0) && (!full || pop);
  assign drop    = rd_done && (samp_q != '0) && full && !pop;

  always_comb begin
    occ_d = occ_q;
    if (push && !pop) occ_d = occ_q + OCC_W'(1);
    else if (pop && !push) occ_d = occ_q - OCC_W'(1);
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      samp_q       <= '0;
      samp_stamp_q <= '0;
      wp_q         <= '0;
      rp_q         <= '0;
      occ_q        <= '0;
      alarm_valid  <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      if (rd_last) begin
        samp_q       <= mdt;
        samp_stamp_q <= stamp_q;
      end
      if (push) wp_q <= wp_q + PTR_W'(1);
      if (pop)  rp_q <= rp_q + PTR_W'(1);
      occ_q       <= occ_d;
      alarm_valid <= (occ_d != '0);
      // Set wins over a simultaneous clear.
      if (drop) ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge SIM_CLK) begin
    if (push) mem[wp_q] <= {samp_q, samp_stamp_q};
  end

  assign alarm_data  = mem[rp_q].data;
  assign alarm_stamp = mem[rp_q].stamp;

endmodule
